// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: response owner tags and
// read-latency limits. The owner enum is also decoded by the trace monitor.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DRD  = 2'd2
   } owner_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   function automatic bit rd_lat_legal(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/mem_port_arb_resp_tag_pipe.sv
// Owner-tag delay line matching the RAM read latency; an asynchronous reset
// drops every in-flight tag so stale read data is never flagged valid.
module resp_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  owner_t tag_in,
   output owner_t tag_out
);

   owner_t stages [DEPTH];

   // NOTE: every stage is reset, not just the head; the tags are control state,
   // and a surviving tag would flag garbage RAM data as a valid response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= OWN_NONE;
      end else begin
         // NOTE: non-blocking assignments let each stage take its neighbour's
         // old value, so the loop order does not matter.
         stages[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arb.sv
// Single-port RAM arbiter: data beats fetch, reads are tagged for return.
// Optional fetch anti-starvation counter when MEM_ARB_FAIRNESS_EN is defined.
module mem_port_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall
);

   if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("mem_port_arb: RD_LAT must be within 1..4");
   end

   logic   fetch_force;
   owner_t tag_in;
   owner_t tag_out;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [CNT_W-1:0] starve_cnt;

   assign fetch_force = (starve_cnt == CNT_W'(STARVE_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (d_req) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign fetch_force = 1'b0;
`endif

   // NOTE: every output of this block gets a default first, so no path through
   // the ifs can leave a signal unassigned and infer a latch.
   always_comb begin
      if_gnt   = 1'b0;
      d_gnt    = 1'b0;
      mem_addr = '0;
      mem_we   = 1'b0;
      mem_be   = '0;
      tag_in   = OWN_NONE;
      if (!rst) begin
         if (if_req && (fetch_force || !d_req)) begin
            if_gnt   = 1'b1;
            mem_addr = if_addr;
            mem_be   = '1;
            tag_in   = OWN_IF;
         end else if (d_req) begin
            d_gnt    = 1'b1;
            mem_addr = d_addr;
            mem_we   = d_we;
            mem_be   = d_be;
            tag_in   = d_we ? OWN_NONE : OWN_DRD;
         end
      end
   end

   // Write data is only sampled with mem_we, so it needs no steering.
   assign mem_wdata = d_wdata;
   assign stall     = if_req & ~if_gnt;

   resp_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign if_rvalid = (tag_out == OWN_IF);
   assign d_rvalid  = (tag_out == OWN_DRD);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule
